// File: rtl/f_wb_scoreboard_pkg.sv
// Shared FPU definitions for the FP writeback / scoreboard slice.
//   NumFpRegs : number of architectural FP registers
//   FlagW     : width of the accrued exception flag field {NV,DZ,OF,UF,NX}
//   fp_wb_t   : one pending register-file write (destination, data, flags)
//   wb_src_e  : which source owns the write port in a given cycle
package f_wb_scoreboard_pkg;

  localparam int unsigned NumFpRegs = 32;
  localparam int unsigned FlagW     = 5;
  localparam int unsigned RegIdxW   = 5;
  localparam int unsigned DataW     = 32;

  typedef struct packed {
    logic [RegIdxW-1:0] rd;
    logic [DataW-1:0]   data;
    logic [FlagW-1:0]   flags;
  } fp_wb_t;

  typedef enum logic [1:0] {
    SrcNone,
    SrcLoad,
    SrcFifo,
    SrcFpu
  } wb_src_e;

endpackage

// File: rtl/f_wb_fifo.sv
// Small holding queue for FPU results that lost write-port arbitration.
//   clk, n_rst   : clock, asynchronous active-low reset (clears pointers/count)
//   push_i       : enqueue push_data_i (ignored when full)
//   pop_i        : dequeue the head entry (ignored when empty)
//   head_o       : oldest entry, valid while empty_o is low
//   empty_o/full_o : occupancy status
module f_wb_fifo
  import f_wb_scoreboard_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic   clk,
  input  logic   n_rst,
  input  logic   push_i,
  input  fp_wb_t push_data_i,
  input  logic   pop_i,
  output fp_wb_t head_o,
  output logic   empty_o,
  output logic   full_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  fp_wb_t          mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FullCnt);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pointers wrap explicitly so non-power-of-two depths work too.
    if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: it is only read when the count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/f_wb_scoreboard.sv
// FP register scoreboard plus single-port register-file writeback arbiter.
//   issue_*        : issue handshake; issue_ready is low while any operand/dest is busy
//   fpu_*          : FPU result stream; fpu_ready is low when the holding queue is full
//   ld_*           : FP load return, always accepted, highest write priority
//   f_wen/f_rd/f_w_data : registered register-file write port
//   fflags / fflags_clr : sticky accrued FP exception flags and their CSR clear
module f_wb_scoreboard
  import f_wb_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS   = NumFpRegs,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               issue_valid,
  input  logic [RegIdxW-1:0] issue_rs1,
  input  logic [RegIdxW-1:0] issue_rs2,
  input  logic [RegIdxW-1:0] issue_rd,
  output logic               issue_ready,
  input  logic               fpu_done,
  input  logic [RegIdxW-1:0] fpu_rd,
  input  logic [DataW-1:0]   fpu_data,
  input  logic [FlagW-1:0]   fpu_flags,
  output logic               fpu_ready,
  input  logic               ld_valid,
  input  logic [RegIdxW-1:0] ld_rd,
  input  logic [DataW-1:0]   ld_data,
  output logic               f_wen,
  output logic [RegIdxW-1:0] f_rd,
  output logic [DataW-1:0]   f_w_data,
  output logic [FlagW-1:0]   fflags,
  input  logic               fflags_clr
);

  fp_wb_t              fpu_res, ld_res, fifo_head, sel;
  wb_src_e             src;
  logic                fifo_empty, fifo_full, fpu_acc, fifo_push, fifo_pop;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                f_wen_q, f_wen_d;
  logic [RegIdxW-1:0]  f_rd_q, f_rd_d;
  logic [DataW-1:0]    f_w_data_q, f_w_data_d;
  logic [FlagW-1:0]    fflags_q, fflags_d;

  // Only registered busy is consulted: a register freed this edge is visible next cycle.
  assign issue_ready = ~busy_q[issue_rs1] & ~busy_q[issue_rs2] & ~busy_q[issue_rd];
  assign fpu_ready   = ~fifo_full;
  assign fpu_acc     = fpu_done & fpu_ready;
  assign fpu_res     = '{rd: fpu_rd, data: fpu_data, flags: fpu_flags};
  assign ld_res      = '{rd: ld_rd, data: ld_data, flags: '0};

  // Write-port arbitration: load, then oldest queued result, then a fresh result.
  always_comb begin
    src = SrcNone;
    sel = '0;
    if (ld_valid) begin
      src = SrcLoad;
      sel = ld_res;
    end else if (!fifo_empty) begin
      src = SrcFifo;
      sel = fifo_head;
    end else if (fpu_acc) begin
      src = SrcFpu;
      sel = fpu_res;
    end
  end

  assign fifo_push = fpu_acc & (src != SrcFpu);
  assign fifo_pop  = (src == SrcFifo);

  f_wb_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .push_i     (fifo_push),
    .push_data_i(fpu_res),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  always_comb begin
    f_wen_d    = (src != SrcNone);
    f_rd_d     = f_wen_d ? sel.rd : f_rd_q;
    f_w_data_d = f_wen_d ? sel.data : f_w_data_q;

    // Clear first so flags written on the clearing edge still accrue.
    fflags_d = fflags_clr ? '0 : fflags_q;
    if (src == SrcFifo || src == SrcFpu) fflags_d = fflags_d | sel.flags;

    // Set after clear: a new issue to a register being written stays outstanding.
    busy_d = busy_q;
    if (f_wen_d) busy_d[sel.rd] = 1'b0;
    if (issue_valid && issue_ready) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_q     <= '0;
      f_wen_q    <= 1'b0;
      f_rd_q     <= '0;
      f_w_data_q <= '0;
      fflags_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      f_wen_q    <= f_wen_d;
      f_rd_q     <= f_rd_d;
      f_w_data_q <= f_w_data_d;
      fflags_q   <= fflags_d;
    end
  end

  assign f_wen    = f_wen_q;
  assign f_rd     = f_rd_q;
  assign f_w_data = f_w_data_q;
  assign fflags   = fflags_q;

endmodule

// File: tb/tb_f_wb_scoreboard.sv
// Directed and random bench for f_wb_scoreboard with a write scoreboard and reference model.
module tb_f_wb_scoreboard;
  import f_wb_scoreboard_pkg::*;

  localparam int unsigned Depth = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        issue_valid, issue_ready, fpu_done, fpu_ready, ld_valid, f_wen, fflags_clr;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, fpu_rd, ld_rd, f_rd, fpu_flags, fflags;
  logic [31:0] fpu_data, ld_data, f_w_data;

  f_wb_scoreboard #(
    .NUM_REGS  (32),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .issue_valid(issue_valid),
    .issue_rs1  (issue_rs1),
    .issue_rs2  (issue_rs2),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .fpu_done   (fpu_done),
    .fpu_rd     (fpu_rd),
    .fpu_data   (fpu_data),
    .fpu_flags  (fpu_flags),
    .fpu_ready  (fpu_ready),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .f_wen      (f_wen),
    .f_rd       (f_rd),
    .f_w_data   (f_w_data),
    .fflags     (fflags),
    .fflags_clr (fflags_clr)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_wr_dut = 0;
  int          n_wr_exp = 0;
  logic [31:0] m_busy;
  logic [4:0]  m_flags;
  logic [4:0]  m_last_rd;
  logic [31:0] m_last_data;
  fp_wb_t      mq[$];
  fp_wb_t      sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    fpu_done = 1'b0; fpu_rd = '0; fpu_data = '0; fpu_flags = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0; fflags_clr = 1'b0;
  endtask

  task automatic model_reset();
    m_busy = '0; m_flags = '0; m_last_rd = '0; m_last_data = '0;
    mq.delete();
    sbq.delete();
  endtask

  // One clock: check handshakes, advance the model, push expected write, check the port.
  task automatic cyc();
    logic   exp_ir, facc, wv, wfpu;
    fp_wb_t w, fresh;
    #1;
    exp_ir = !m_busy[issue_rs1] && !m_busy[issue_rs2] && !m_busy[issue_rd];
    chk("issue_ready", 32'(issue_ready), 32'(exp_ir));
    chk("fpu_ready", 32'(fpu_ready), 32'(mq.size() < Depth));
    fresh = '{rd: fpu_rd, data: fpu_data, flags: fpu_flags};
    facc = fpu_done && (mq.size() < Depth);
    wv = 1'b1;
    wfpu = 1'b0;
    w = '0;
    if (ld_valid) w = '{rd: ld_rd, data: ld_data, flags: 5'b0};
    else if (mq.size() > 0) begin
      w = mq.pop_front();
      wfpu = 1'b1;
    end else if (facc) begin
      w = fresh;
      wfpu = 1'b1;
      facc = 1'b0;
    end else wv = 1'b0;
    if (facc) mq.push_back(fresh);
    if (fflags_clr) m_flags = '0;
    if (wfpu) m_flags = m_flags | w.flags;
    if (wv) begin
      m_busy[w.rd] = 1'b0;
      sbq.push_back(w);
      n_wr_exp++;
      m_last_rd = w.rd;
      m_last_data = w.data;
    end
    if (issue_valid && exp_ir) m_busy[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
    chk("f_wen", 32'(f_wen), 32'(wv));
    if (f_wen) n_wr_dut++;
    if (f_wen && sbq.size() > 0) begin
      w = sbq.pop_front();
      chk("sb_rd", 32'(f_rd), 32'(w.rd));
      chk("sb_data", f_w_data, w.data);
    end else begin
      chk("hold_rd", 32'(f_rd), 32'(m_last_rd));
      chk("hold_data", f_w_data, m_last_data);
    end
    chk("fflags", 32'(fflags), 32'(m_flags));
  endtask

  initial begin
    idle();
    model_reset();
    #2;
    chk("rst_f_wen", 32'(f_wen), 32'(0));
    chk("rst_f_rd", 32'(f_rd), 32'(0));
    chk("rst_f_w_data", f_w_data, 32'(0));
    chk("rst_fflags", 32'(fflags), 32'(0));
    @(posedge clk);
    #3 n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_issue_ready", 32'(issue_ready), 32'(1));
    chk("post_rst_fpu_ready", 32'(fpu_ready), 32'(1));

    // RAW hazard on f3 held until its write lands.
    issue_valid = 1'b1; issue_rd = 5'd3; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
    cyc();
    issue_rs1 = 5'd3; issue_rs2 = 5'd0; issue_rd = 5'd4;
    chk("raw_blocked", 32'(issue_ready), 32'(0));
    cyc();
    cyc();
    fpu_done = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h11; fpu_flags = 5'b0;
    cyc();
    fpu_done = 1'b0;
    chk("raw_wen", 32'(f_wen), 32'(1));
    chk("raw_wr_rd", 32'(f_rd), 32'(3));
    chk("raw_released", 32'(issue_ready), 32'(1));
    cyc();
    issue_valid = 1'b0;
    fpu_done = 1'b1; fpu_rd = 5'd4; fpu_data = 32'h22;
    cyc();
    fpu_done = 1'b0;

    // Load beats a simultaneous FPU result.
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h3F80_0000;
    fpu_done = 1'b1; fpu_rd = 5'd6; fpu_data = 32'h4000_0000; fpu_flags = 5'b00001;
    cyc();
    ld_valid = 1'b0; fpu_done = 1'b0;
    chk("pri_ld_rd", 32'(f_rd), 32'(5));
    chk("pri_ld_data", f_w_data, 32'h3F80_0000);
    chk("pri_ld_fflags", 32'(fflags), 32'(0));
    cyc();
    chk("pri_fpu_rd", 32'(f_rd), 32'(6));
    chk("pri_fpu_data", f_w_data, 32'h4000_0000);
    chk("pri_fpu_fflags", 32'(fflags), 32'(1));

    // Clear and accrue on the same edge.
    fflags_clr = 1'b1; fpu_done = 1'b1; fpu_rd = 5'd8; fpu_data = 32'h33; fpu_flags = 5'b10000;
    cyc();
    fflags_clr = 1'b0; fpu_done = 1'b0;
    chk("clr_accrue", 32'(fflags), 32'(5'b10000));

    // Fill the queue behind loads, then drain in order.
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = 32'(32'hA0 + i);
      fpu_done = 1'b1; fpu_rd = 5'(20 + i); fpu_data = 32'(32'h100 + i); fpu_flags = 5'(i);
      #1 chk("fill_fpu_ready", 32'(fpu_ready), 32'(i < 2));
      cyc();
      chk("fill_ld_rd", 32'(f_rd), 32'(10 + i));
    end
    ld_valid = 1'b0;
    cyc();
    chk("drain0_rd", 32'(f_rd), 32'(20));
    cyc();
    chk("drain1_rd", 32'(f_rd), 32'(21));
    fpu_done = 1'b0;
    cyc();
    chk("drain2_rd", 32'(f_rd), 32'(22));

    // Reset with f7 busy and one result queued.
    issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd7;
    cyc();
    issue_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h55;
    fpu_done = 1'b1; fpu_rd = 5'd12; fpu_data = 32'h66; fpu_flags = 5'b00010;
    cyc();
    n_rst = 1'b0;
    issue_rs1 = 5'd7; issue_rs2 = 5'd7; issue_rd = 5'd7;
    fpu_rd = 5'd13; ld_rd = 5'd14;
    #1;
    model_reset();
    chk("arst_f_wen", 32'(f_wen), 32'(0));
    chk("arst_f_rd", 32'(f_rd), 32'(0));
    chk("arst_f_w_data", f_w_data, 32'(0));
    chk("arst_fflags", 32'(fflags), 32'(0));
    chk("arst_busy7", 32'(issue_ready), 32'(1));
    chk("arst_fpu_ready", 32'(fpu_ready), 32'(1));
    repeat (2) begin
      @(posedge clk);
      #1 chk("in_rst_f_wen", 32'(f_wen), 32'(0));
    end
    ld_valid = 1'b0; fpu_done = 1'b0;
    #3 n_rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cyc();

    // Random traffic against the model.
    repeat (300) begin
      issue_valid = 1'($urandom_range(1));
      issue_rs1 = 5'($urandom_range(31));
      issue_rs2 = 5'($urandom_range(31));
      issue_rd = 5'($urandom_range(31));
      fpu_done = 1'($urandom_range(1));
      fpu_rd = 5'($urandom_range(31));
      fpu_data = $urandom;
      fpu_flags = 5'($urandom_range(31));
      ld_valid = ($urandom_range(3) == 0);
      ld_rd = 5'($urandom_range(31));
      ld_data = $urandom;
      fflags_clr = ($urandom_range(15) == 0);
      cyc();
    end
    idle();
    repeat (4) cyc();
    for (int r = 0; r < 32; r++) begin
      issue_rs1 = 5'(r); issue_rs2 = 5'(r); issue_rd = 5'(r);
      #1 chk("final_busy", 32'(issue_ready), 32'(!m_busy[r]));
    end
    chk("write_count", 32'(n_wr_dut), 32'(n_wr_exp));
    chk("sb_empty", 32'(sbq.size()), 32'(0));
    chk("model_fifo_empty", 32'(mq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/f_wb_scoreboard.md
F_WB_SCOREBOARD -- requirements
Module: f_wb_scoreboard

Interface
REQ-001 SHALL use parameter NUM_REGS, default 32, number of FP registers tracked.
REQ-002 SHALL use parameter FIFO_DEPTH, default 2, number of FPU-result holding entries.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and n_rst as elsewhere in the codebase.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 n_rst  in  1  asynchronous active-low reset.
REQ-006 issue_valid  in  1  FP instruction requests issue.
REQ-007 issue_rs1, issue_rs2, issue_rd  in  5 each  source and destination register indices.
REQ-008 issue_ready  out  1  issue accepted this cycle when high together with issue_valid.
REQ-009 fpu_done  in  1  FPU result valid.
REQ-010 fpu_rd  in  5  FPU result destination.
REQ-011 fpu_data  in  32  FPU result.
REQ-012 fpu_flags  in  5  {NV,DZ,OF,UF,NX}.
REQ-013 fpu_ready  out  1  FPU result accepted when high with fpu_done.
REQ-014 ld_valid  in  1  FP load data return, always accepted.
REQ-015 ld_rd  in  5  load destination.
REQ-016 ld_data  in  32  load data.
REQ-017 f_wen  out  1  register-file write enable.
REQ-018 f_rd  out  5  register-file write index.
REQ-019 f_w_data  out  32  register-file write data.
REQ-020 fflags  out  5  sticky accrued exception flags.
REQ-021 fflags_clr  in  1  CSR write clearing fflags.

Function
REQ-022 SHALL hold a NUM_REGS-bit busy vector; issue_ready = issue_valid-independent AND of !busy[rs1], !busy[rs2], !busy[rd], computed only from registered busy, with no same-cycle bypass.
REQ-023 On accepted issue, SHALL set busy[issue_rd] on the next edge.
REQ-024 SHALL drive the single write port registered (1-cycle latency) with priority: load > FIFO head > fresh FPU result.
REQ-025 A fresh FPU result not selected in its acceptance cycle SHALL be enqueued; fpu_ready = (FIFO count < FIFO_DEPTH).
REQ-026 Simultaneous enqueue and dequeue SHALL leave the count unchanged; FIFO order is preserved; pointers wrap modulo FIFO_DEPTH.
REQ-027 On each write the port performs, SHALL clear busy[written rd] on the same edge that asserts f_wen.
REQ-028 On each write of an FPU result, SHALL OR that result's flags into fflags on the same edge; load writes SHALL leave fflags unchanged.
REQ-029 fflags_clr SHALL zero fflags, except that flags from an FPU write on that same edge SHALL be ORed in after the clear.
REQ-030 When the FIFO is full and no load is present, SHALL drain one entry per cycle.
REQ-031 f_wen SHALL be low in every cycle with no selected source; f_rd and f_w_data SHALL then hold their previous values.

Reset
REQ-032 While n_rst is low, SHALL force busy, the FIFO (count and pointers), f_wen, f_rd, f_w_data and fflags to 0, asynchronously.
REQ-033 Results arriving during reset SHALL be discarded.
REQ-034 After n_rst deasserts, issue_ready and fpu_ready SHALL be high.

Structure
REQ-035 SHALL take NUM_REGS, the flag-width constant and typedef fp_wb_t {rd[4:0], data[31:0], flags[4:0]} from the shared FPU package.
REQ-036 SHALL instantiate the holding queue as sub-module f_wb_fifo, parameterised by FIFO_DEPTH.

Verification
REQ-037 Issue rd=3, rs1=1, rs2=2, then issue rs1=3 on the next cycle -> the second issue sees issue_ready=0 until the cycle after f_wen writes rd=3.
REQ-038 ld_valid (rd=5, data=0x3F800000) and fpu_done (rd=6, data=0x40000000, flags=00001) in the same cycle -> cycle+1: write rd=5; cycle+2: write rd=6 with fflags=00001.
REQ-039 Three FPU results are offered back-to-back while a load is present in each of those cycles -> the first two are enqueued, fpu_ready=0 in the third, and they drain in order once the loads stop.
REQ-040 fflags_clr on the same edge as an FPU write with flags=10000 -> fflags=10000.
REQ-041 Assert n_rst low with busy[7]=1 and the FIFO holding one entry -> busy=0, FIFO empty, and no f_wen after reset.
REQ-042 Random issue/FPU/load traffic checked against a reference model -> no lost or duplicated write, and busy matches outstanding destinations.
